// File: rtl/output_limit_fifo_pkg.sv
// Shared widths and constants for the outbound byte-to-word FIFO.
// Also holds the grant saturation helper.
package output_limit_fifo_pkg;

  localparam int unsigned OUTFIFO_WORD_W  = 16;
  localparam int unsigned OUTFIFO_BYTE_W  = 8;
  localparam int unsigned OUTFIFO_LIMIT_W = 16;

  localparam logic [OUTFIFO_LIMIT_W-1:0] OUTFIFO_LIMIT_MAX = 16'hFFFF;

  typedef logic [OUTFIFO_WORD_W-1:0] outfifo_word_t;

  // Clamp a word count to the width of the grant register.
  function automatic logic [OUTFIFO_LIMIT_W-1:0] sat_limit(input int unsigned n);
    if (n > 32'(OUTFIFO_LIMIT_MAX)) begin
      return OUTFIFO_LIMIT_MAX;
    end
    return n[OUTFIFO_LIMIT_W-1:0];
  endfunction

endpackage

// File: rtl/byte_packer_8to16.sv
// Packs pairs of bytes into little-endian 16-bit words.
// The first byte of a pair is held until its partner arrives.
module byte_packer_8to16
  import output_limit_fifo_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [OUTFIFO_BYTE_W-1:0] din,
  input  logic                      wr_en,
  input  logic                      stall,
  output logic                      word_valid,
  output logic [OUTFIFO_WORD_W-1:0] word
);

  logic                      pending_q;
  logic [OUTFIFO_BYTE_W-1:0] lo_byte_q;
  logic                      accept;

  assign accept     = wr_en & ~stall;
  assign word_valid = accept & pending_q;
  assign word       = {din, lo_byte_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      lo_byte_q <= '0;
    end else if (accept) begin
      pending_q <= ~pending_q;
      if (!pending_q) begin
        lo_byte_q <= din;
      end
    end
  end

endmodule

// File: rtl/output_limit_fifo.sv
// Outbound FIFO: bytes in from the core, 16-bit words out to the host,
// with words only readable after the host grants them via output_limit_en.
module output_limit_fifo
  import output_limit_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2      = 10,
  parameter int unsigned ALMOST_FULL_GAP = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [OUTFIFO_BYTE_W-1:0]  din,
  input  logic                       wr_en,
  output logic                       full,
  output logic                       almost_full,
  output logic [OUTFIFO_WORD_W-1:0]  dout,
  input  logic                       rd_en,
  output logic                       empty,
  input  logic                       output_limit_en,
  output logic [OUTFIFO_LIMIT_W-1:0] output_limit,
  output logic                       output_limit_done
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  outfifo_word_t mem [DEPTH];

  logic [DEPTH_LOG2-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [OUTFIFO_LIMIT_W-1:0] limit_cnt_q, limit_cnt_d;
  logic [OUTFIFO_LIMIT_W-1:0] output_limit_q, grant_val;
  logic                       grant_q, done_q;
  logic                       almost_full_q, almost_full_d;
  logic                       word_valid;
  outfifo_word_t              word;
  logic                       rd_acc;

  byte_packer_8to16 u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .wr_en      (wr_en),
    .stall      (full),
    .word_valid (word_valid),
    .word       (word)
  );

  assign full              = (count_q == CNT_W'(DEPTH));
  // count==0 implies limit_cnt==0; the extra term guards the invariant anyway.
  assign empty             = (limit_cnt_q == '0) | (count_q == '0);
  assign rd_acc            = rd_en & ~empty;
  assign dout              = mem[rd_ptr_q];
  assign almost_full       = almost_full_q;
  assign output_limit      = output_limit_q;
  assign output_limit_done = done_q;

  always_comb begin
    count_d = count_q;
    if (word_valid && !rd_acc) begin
      count_d = count_q + CNT_W'(1);
    end else if (!word_valid && rd_acc) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // A word committed in the same cycle as the request is not part of the grant.
  assign grant_val = sat_limit(32'(count_q) - 32'(rd_acc));

  always_comb begin
    limit_cnt_d = limit_cnt_q - OUTFIFO_LIMIT_W'(rd_acc);
    if (output_limit_en) begin
      limit_cnt_d = grant_val;
    end
  end

  assign almost_full_d = (DEPTH - 32'(count_d)) <= ALMOST_FULL_GAP;

  always_ff @(posedge clk) begin
    if (word_valid) begin
      mem[wr_ptr_q] <= word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      limit_cnt_q    <= '0;
      output_limit_q <= '0;
      grant_q        <= 1'b0;
      done_q         <= 1'b0;
      almost_full_q  <= 1'b0;
    end else begin
      if (word_valid) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      end
      count_q       <= count_d;
      limit_cnt_q   <= limit_cnt_d;
      almost_full_q <= almost_full_d;
      if (output_limit_en) begin
        output_limit_q <= grant_val;
      end
      grant_q <= output_limit_en;
      done_q  <= grant_q;
    end
  end

endmodule

// File: tb/tb_output_limit_fifo.sv
// Randomised and directed bench for output_limit_fifo against a queue-based model.
module tb_output_limit_fifo;

  localparam int DEPTH = 1024;
  localparam int GAP   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        wr_en;
  logic        full;
  logic        almost_full;
  logic [15:0] dout;
  logic        rd_en;
  logic        empty;
  logic        output_limit_en;
  logic [15:0] output_limit;
  logic        output_limit_done;

  output_limit_fifo dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .din               (din),
    .wr_en             (wr_en),
    .full              (full),
    .almost_full       (almost_full),
    .dout              (dout),
    .rd_en             (rd_en),
    .empty             (empty),
    .output_limit_en   (output_limit_en),
    .output_limit      (output_limit),
    .output_limit_done (output_limit_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: committed words, the half-word byte, granted words, last grant.
  logic [15:0] m_q[$];
  logic        m_pend;
  logic [7:0]  m_lo;
  int          m_granted;
  int          m_limit;
  logic        m_last_en;
  logic        m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend    = 1'b0;
    m_lo      = '0;
    m_granted = 0;
    m_limit   = 0;
    m_last_en = 1'b0;
    m_done    = 1'b0;
  endtask

  task automatic check_all();
    chk("full", 32'(full), 32'(m_q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'((DEPTH - m_q.size()) <= GAP));
    chk("empty", 32'(empty), 32'(m_granted == 0));
    chk("output_limit", 32'(output_limit), 32'(m_limit));
    chk("done", 32'(output_limit_done), 32'(m_done));
  endtask

  // One clock cycle with the given inputs; entered and left at posedge+1.
  task automatic step(input logic w, input logic [7:0] b, input logic r, input logic l);
    logic acc_w, acc_r;
    int   g;
    wr_en = w; din = b; rd_en = r; output_limit_en = l;
    acc_w = w && (m_q.size() != DEPTH);
    acc_r = r && (m_granted != 0);
    if (m_granted != 0) chk("dout", 32'(dout), 32'(m_q[0]));
    g = m_q.size() - (acc_r ? 1 : 0);
    @(posedge clk); #1;
    if (acc_r) void'(m_q.pop_front());
    if (acc_w) begin
      if (m_pend) begin
        m_q.push_back({b, m_lo});
        m_pend = 1'b0;
      end else begin
        m_lo   = b;
        m_pend = 1'b1;
      end
    end
    if (l) begin
      m_granted = (g > 65535) ? 65535 : g;
      m_limit   = m_granted;
    end else if (acc_r) begin
      m_granted--;
    end
    m_done    = m_last_en;
    m_last_en = l;
    check_all();
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; din = '0; rd_en = 1'b0; output_limit_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int target;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check_all();
    chk("reset_dout_gate_empty", 32'(empty), 32'd1);
    do_reset();

    // Basic packing and first grant.
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    chk("pend_not_granted_empty", 32'(empty), 32'd1);
    step(0, 0, 0, 1);
    chk("first_limit", 32'(output_limit), 32'd1);
    chk("first_dout", 32'(dout), 32'h2211);
    step(0, 0, 0, 0);
    chk("first_done", 32'(output_limit_done), 32'd1);
    step(0, 0, 0, 0);
    chk("done_one_cycle", 32'(output_limit_done), 32'd0);

    // Fill to full, extra bytes dropped, grant and drain.
    do_reset();
    for (int i = 0; i < 2048; i++) begin
      step(1, 8'(i), 0, 0);
      if (i == 2039) chk("af_at_1020", 32'(almost_full), 32'd1);
      if (i == 2037) chk("af_below_1020", 32'(almost_full), 32'd0);
    end
    chk("full_after_2048", 32'(full), 32'd1);
    step(1, 8'hEE, 0, 0);
    step(1, 8'hEF, 0, 0);
    step(0, 0, 0, 1);
    chk("full_limit", 32'(output_limit), 32'd1024);
    for (int i = 0; i < 1024; i++) begin
      if (i == 1) chk("fill_word1", 32'(dout), 32'h0302);
      step(0, 0, 1, 0);
    end
    chk("drained_empty", 32'(empty), 32'd1);

    // Re-grant covers older granted words still stored.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h80 + i), 0, 0);
    step(0, 0, 0, 1);
    chk("regrant_limit", 32'(output_limit), 32'd4);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("regrant_empty", 32'(empty), 32'd1);

    // Grant, accepted read and word commit all in one cycle.
    do_reset();
    for (int i = 0; i < 11; i++) step(1, 8'(8'hA0 + i), 0, 0);
    step(0, 0, 0, 1);
    step(1, 8'hC7, 1, 1);
    chk("same_cycle_limit", 32'(output_limit), 32'd4);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("same_cycle_empty", 32'(empty), 32'd1);
    step(0, 0, 0, 1);
    chk("same_cycle_left", 32'(output_limit), 32'd1);

    // 3000 words in bursts of 100 through the wrapping pointers.
    do_reset();
    for (int burst = 0; burst < 30; burst++) begin
      target = m_q.size() + 100;
      guard  = 0;
      while (m_q.size() < target && guard < 2000) begin
        step($urandom_range(0, 3) != 0, 8'($urandom), 0, 0);
        guard++;
      end
      chk("burst_fill_bound", 32'(m_q.size() >= target), 32'd1);
      step(0, 0, 0, 1);
      guard = 0;
      while (m_granted != 0 && guard < 2000) begin
        step($urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 3) != 0, 0);
        guard++;
      end
      chk("burst_drain_bound", 32'(m_granted), 32'd0);
    end

    // Asynchronous reset mid-burst with 37 words and a pending byte.
    do_reset();
    for (int i = 0; i < 74; i++) step(1, 8'($urandom), 0, 0);
    step(0, 0, 0, 1);
    step(1, 8'h99, 0, 0);
    chk("pre_reset_limit", 32'(output_limit), 32'd37);
    #3;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 8'hA5, 0, 0);
    step(1, 8'h5A, 0, 0);
    step(0, 0, 0, 1);
    chk("post_reset_limit", 32'(output_limit), 32'd1);
    chk("post_reset_word", 32'(dout), 32'h5AA5);
    step(0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_limit_fifo.md
Name: output_limit_fifo

Overview:
- Outbound-direction FIFO: the computing core writes 8-bit result bytes; the USB/host side reads 16-bit words.
- Bytes are packed in pairs, little-endian: the first byte goes to dout[7:0].
- Words become readable only after the host grants them with an output-limit request. The host therefore always knows exactly how many words it may fetch in one transfer.
- Single clock domain. It sits between the core's result path and the host read interface.

Parameters:
- DEPTH_LOG2, 10, log2 of word storage depth (1024 x 16-bit words).
- ALMOST_FULL_GAP, 4, almost_full asserts when free words <= this value.

Ports:
- clk  in  1  sole clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  8  byte from core.
- wr_en  in  1  byte write strobe; ignored while full=1.
- full  out  1  no byte can be accepted this cycle.
- almost_full  out  1  free words <= ALMOST_FULL_GAP.
- dout  out  16  first-word-fall-through data; valid while empty=0.
- rd_en  in  1  word read strobe; ignored while empty=1.
- empty  out  1  no granted word is available.
- output_limit_en  in  1  one-cycle request: grant all stored words.
- output_limit  out  16  number of words granted by the last request.
- output_limit_done  out  1  one-cycle pulse, the cycle after output_limit is updated.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_ptr=rd_ptr=0, count=0, pending=0, limit_cnt=0.
  - output_limit=0, output_limit_done=0, full=0, almost_full=0, empty=1.
  - Leaving reset mid-transfer discards all stored words and any pending half-word.
- Packer:
  - Accepted byte with pending=0: latch the byte into lo_byte, set pending=1.
  - Accepted byte with pending=1: write {din, lo_byte} to mem[wr_ptr], increment wr_ptr (wraps modulo 2^DEPTH_LOG2), clear pending.
  - A byte is accepted when wr_en & ~full.
- full = (count == 2^DEPTH_LOG2). While full, no byte is accepted, including into the pending register.
- count tracks committed words (DEPTH_LOG2+1 bits):
  - +1 on word commit, -1 on accepted read.
  - Both in the same cycle: count unchanged.
- Read side:
  - dout = mem[rd_ptr] (asynchronous-read storage), zero latency.
  - empty = (limit_cnt == 0).
  - An accepted read (rd_en & ~empty) increments rd_ptr (with wrap) and decrements limit_cnt and count.
- Limit grant, on output_limit_en:
  - g = count - (accepted read this cycle ? 1 : 0). A word committed in the same cycle is excluded.
  - g is saturated to 16'hFFFF.
  - limit_cnt <= g; output_limit <= g; output_limit_done asserts on the next cycle for exactly one cycle.
  - A request while limit_cnt != 0 re-grants: the new value replaces the old one. Previously granted words are still stored, so they are included in g.
- Invariants:
  - limit_cnt <= count at all times.
  - A pending half-word is never counted or granted.
  - count=0 forces empty=1 regardless of history.
- Latency:
  - A byte pair completed at cycle t is counted at t+1.
  - It is readable no earlier than the cycle after the next output_limit_en.
- almost_full = (2^DEPTH_LOG2 - count) <= ALMOST_FULL_GAP. It is registered from next-state values, so it is coincident with count.

Decomposition:
- Shared package holds:
  - OUTFIFO_WORD_W=16 and OUTFIFO_BYTE_W=8.
  - OUTFIFO_LIMIT_W=16.
  - The saturation constant 16'hFFFF.
- Sub-module byte_packer_8to16: owns pending and lo_byte. It emits a word strobe plus the 16-bit word, and takes a stall input driven by full.
- The top module holds storage, pointers, count, limit logic and flags.

Test Plan:
- Reset, then write bytes 0x11,0x22,0x33 -> count=1, pending=1, empty=1. Pulse output_limit_en -> output_limit=1, done pulse next cycle, dout=16'h2211, empty=0.
- Write 2048 bytes (0x00..0xFF repeating), then 2 more -> full=1 after byte 2048. almost_full rises at count=1020. The extra bytes are ignored. Grant -> output_limit=1024. Reading all 1024 words returns 16'h0100, 16'h0302, ... in order.
- Grant 4 words, read 2, write 2 more words, grant again -> output_limit=4 (2 old + 2 new). Reading 4 then gives empty=1 while count=0.
- Same cycle: output_limit_en, an accepted read and a word commit with count=5 -> output_limit=4. count stays 5, limit_cnt=4.
- Pointer wrap: cycle 3000 words through in bursts of 100 grant/read -> data stays in order across wrap, no spurious full or empty.
- Assert rst_n=0 mid-burst with count=37, pending=1 -> all outputs return to their reset values immediately (asynchronously). The first word after release comes from bytes written after reset.
